ls165_serializer: RTL and testbench
===================================

// Module: ls165_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter, the counterpart of the D-latch storage in the
//  logic library: 8-bit words enter via valid/ready and leave MSB-first on QH at one
//  bit per enabled clock. ls165-style shift core plus a holding register gives
//  gapless back-to-back words. Feeds the video pixel path from character/bitmap ROM bytes.
// PARAMETERS
//  WIDTH      8   bits per word (>=2)
//  LSB_FIRST  0   1 = shift out bit 0 first; 0 = MSB first
// PORTS
//  _CLK      in   1      single clock, all state changes on rising edge
//  _CLR      in   1      reset: synchronous, active-low
//  DIN       in   WIDTH  parallel word
//  DVALID    in   1      DIN valid
//  DREADY    out  1      holding register can accept DIN
//  SH_EN     in   1      shift enable (ls165 CLK INH inverted); 0 freezes shifting
//  QH        out  1      serial data out
//  QHINV     out  1      ~QH
//  FRAME     out  1      high while first bit of a word is on QH
//  BUSY      out  1      a word is being shifted
//  UNDERRUN  out  1      1-cycle pulse: word finished with holding register empty
// BEHAVIOUR
//  - Reset (_CLR=0 at edge): sreg=0, hold_full=0, cnt=0, state=IDLE, UNDERRUN=0.
//    Outputs while/after reset: QH=0, QHINV=1, FRAME=0, BUSY=0, UNDERRUN=0.
//    DREADY = _CLR & ~hold_full (0 during reset, 1 first cycle after release).
//  - Accept: DVALID&DREADY at edge -> hold<=DIN, hold_full<=1. No accept while full.
//  - States IDLE, SHIFT. BUSY = (state==SHIFT).
//  - IDLE & hold_full at edge (SH_EN ignored): sreg<=hold, hold_full<=0, cnt<=0,
//    state<=SHIFT, FRAME<=1. Latency: word accepted at edge N -> bit 0 on QH after N+1.
//  - SHIFT & SH_EN=1 & cnt<WIDTH-1: shift sreg one place, cnt++, FRAME<=0.
//  - SHIFT & SH_EN=1 & cnt==WIDTH-1: if hold_full -> reload (as IDLE load, FRAME<=1,
//    no gap); else state<=IDLE, sreg<=0, UNDERRUN<=1 for one cycle.
//  - SHIFT & SH_EN=0: sreg, cnt, FRAME, state hold; accepts still allowed.
//  - QH = sreg[WIDTH-1] (or sreg[0] if LSB_FIRST); registered, no comb path from DIN.
//  - Simultaneous accept and reload in the same edge cannot occur (DREADY=0 when full).
//  - Reset mid-word: word and held word discarded, no UNDERRUN.
//  - cnt width $clog2(WIDTH); never exceeds WIDTH-1.
// STRUCTURE
//  - Package ls165_serializer_pkg: state enum {IDLE, SHIFT}.
//  - Sub-module ls165_shift: WIDTH-bit shift register with sync load, shift enable,
//    sync active-low clear, LSB_FIRST. Control FSM, counter, hold register in top.
// TESTING (WIDTH=8, LSB_FIRST=0)
//  1 _CLR=0 for 2 edges with DVALID=1, DIN=8'hFF -> QH=0, QHINV=1, DREADY=0, BUSY=0;
//    after release DREADY=1, nothing accepted.
//  2 Send 8'hA5, SH_EN=1 -> QH=1,0,1,0,0,1,0,1 after edges N+1..N+8; FRAME only on
//    first bit; UNDERRUN pulse after 8th bit; BUSY falls; QH=0.
//  3 Send 8'hF0 then 8'h0F -> 16 contiguous bits 1111000000001111, FRAME on bits 1
//    and 9, no UNDERRUN until after bit 16.
//  4 8'hC3 with SH_EN toggling 1/0 each cycle -> each bit held 2 cycles, sequence
//    1,1,0,0,0,0,1,1 intact, QHINV always ~QH.
//  5 Three words offered back-to-back -> DREADY=0 after second accept until first
//    word's 8th bit reloads; all 24 bits output in order.
//  6 8'h81 mid-word (after 3 bits) _CLR=0 -> next cycle QH=0, BUSY=0, DREADY=0,
//    UNDERRUN=0; after release fresh 8'h55 shifts out correctly.

Source files
------------

// File: rtl/ls165_serializer_pkg.sv
// ----------------------------------------------------------------------------
// ls165_serializer_pkg
// Shared types for the ls165-style parallel-in/serial-out transmitter.
//   state_t : control state of the serializer (IDLE waiting for a word,
//             SHIFT while a word is being clocked out on QH).
// ----------------------------------------------------------------------------
package ls165_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/ls165_serializer_shift.sv
// ----------------------------------------------------------------------------
// ls165_shift
// WIDTH-bit shift register modelled on the 74LS165: synchronous parallel load,
// shift enable and a synchronous active-low clear. The serial output is the
// bit that leaves the register next (MSB or LSB depending on LSB_FIRST).
// Ports:
//   i_CLK    : clock, rising edge
//   i_CLR    : synchronous clear, active-low (highest priority)
//   i_LOAD   : load i_D into the register (beats shifting)
//   i_SH_EN  : shift one place toward the output end
//   i_D      : parallel data
//   o_QH     : serial output, straight from a register bit
// ----------------------------------------------------------------------------
module ls165_shift #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             i_CLK,
   input  logic             i_CLR,
   input  logic             i_LOAD,
   input  logic             i_SH_EN,
   input  logic [WIDTH-1:0] i_D,
   output logic             o_QH
);

   logic [WIDTH-1:0] r_sreg;

   // Clear wins over load, load wins over shift. Vacated positions fill with
   // zero so an idle line reads 0 once the last bit has gone.
   always_ff @(posedge i_CLK) begin
      if (!i_CLR) begin
         r_sreg <= '0;
      end else if (i_LOAD) begin
         r_sreg <= i_D;
      end else if (i_SH_EN) begin
         if (LSB_FIRST) begin
            r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
         end else begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   // The output end of the register is the serial line.
   assign o_QH = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

endmodule

// File: rtl/ls165_serializer.sv
// ----------------------------------------------------------------------------
// ls165_serializer
// Parallel-in/serial-out transmitter. Words arrive over a valid/ready
// handshake into a one-word holding register and are shifted out one bit per
// enabled clock. When a word's last bit is consumed and another word is
// already held, it is loaded on the same edge so consecutive words leave
// without a gap.
// Ports:
//   i_CLK       : clock, rising edge
//   i_CLR       : synchronous reset, active-low
//   i_DIN       : parallel word
//   i_DVALID    : i_DIN is valid
//   o_DREADY    : holding register can take i_DIN
//   i_SH_EN     : shift enable; 0 freezes the word in flight
//   o_QH        : serial data out
//   o_QHINV     : inverted serial data out
//   o_FRAME     : high while the first bit of a word is on o_QH
//   o_BUSY      : a word is being shifted
//   o_UNDERRUN  : one-cycle pulse when a word ends with nothing held
// ----------------------------------------------------------------------------
module ls165_serializer
   import ls165_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             i_CLK,
   input  logic             i_CLR,
   input  logic [WIDTH-1:0] i_DIN,
   input  logic             i_DVALID,
   output logic             o_DREADY,
   input  logic             i_SH_EN,
   output logic             o_QH,
   output logic             o_QHINV,
   output logic             o_FRAME,
   output logic             o_BUSY,
   output logic             o_UNDERRUN
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_hold;
   logic             r_holdFull;
   logic [CNT_W-1:0] r_cnt;
   logic             r_frame;
   logic             r_underrun;
   logic             w_accept;
   logic             w_lastBit;
   logic             w_load;
   logic             w_shift;
   logic             w_finish;
   logic             w_shiftClrN;
   logic             w_qh;

   // Ready is also forced low while reset is asserted so nothing offered
   // during reset is taken.
   assign o_DREADY  = i_CLR & ~r_holdFull;
   assign w_accept  = i_DVALID & o_DREADY;
   assign w_lastBit = (r_cnt == LAST_CNT);

   // State register.
   always_ff @(posedge i_CLK) begin
      if (!i_CLR) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: leave IDLE as soon as a word is held (shift enable does not
   // gate the first load); return to IDLE only when the last bit is consumed
   // and no follow-on word is waiting.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (r_holdFull) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (i_SH_EN && w_lastBit && !r_holdFull) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Control decode: load a new word, shift the current one, or finish and
   // drain. A reload at the last bit is what keeps back-to-back words gapless.
   always_comb begin
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         IDLE: begin
            w_load = r_holdFull;
         end
         SHIFT: begin
            if (i_SH_EN) begin
               if (!w_lastBit) begin
                  w_shift = 1'b1;
               end else if (r_holdFull) begin
                  w_load = 1'b1;
               end else begin
                  w_finish = 1'b1;
               end
            end
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // Holding register data needs no reset; r_holdFull says whether it counts.
   always_ff @(posedge i_CLK) begin
      if (w_accept) begin
         r_hold <= i_DIN;
      end
   end

   // Holding-register flag, bit counter and the registered FRAME/UNDERRUN
   // flags. Accept and load never coincide: accepting needs the register
   // empty, loading needs it full.
   always_ff @(posedge i_CLK) begin
      if (!i_CLR) begin
         r_holdFull <= 1'b0;
         r_cnt      <= '0;
         r_frame    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_finish;
         if (w_load) begin
            r_holdFull <= 1'b0;
         end else if (w_accept) begin
            r_holdFull <= 1'b1;
         end
         if (w_load) begin
            r_cnt   <= '0;
            r_frame <= 1'b1;
         end else if (w_shift) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_frame <= 1'b0;
         end else if (w_finish) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
         end
      end
   end

   // Finishing a word clears the shift register so the idle line reads 0.
   assign w_shiftClrN = i_CLR & ~w_finish;

   ls165_shift #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .i_CLK   (i_CLK),
      .i_CLR   (w_shiftClrN),
      .i_LOAD  (w_load),
      .i_SH_EN (w_shift),
      .i_D     (r_hold),
      .o_QH    (w_qh)
   );

   assign o_QH       = w_qh;
   assign o_QHINV    = ~w_qh;
   assign o_FRAME    = r_frame;
   assign o_BUSY     = (r_state == SHIFT);
   assign o_UNDERRUN = r_underrun;

endmodule

// File: tb/tb_ls165_serializer.sv
// ----------------------------------------------------------------------------
// tb_ls165_serializer
// Self-checking bench for ls165_serializer (WIDTH=8, MSB first). A behavioural
// model keeps pending words in a queue and the word in flight as a value plus
// a bit index; expected outputs are derived from those every cycle.
// ----------------------------------------------------------------------------
module tb_ls165_serializer;

   logic       clk = 1'b0;
   logic       clrN = 1'b0;
   logic [7:0] din = 8'h00;
   logic       dvalid = 1'b0;
   logic       shEn = 1'b0;
   logic       dready;
   logic       qh;
   logic       qhInv;
   logic       frame;
   logic       busy;
   logic       underrun;

   int vectorCount = 0;
   int missCount   = 0;

   logic [7:0]  mPend[$];
   logic [7:0]  mCur = 8'h00;
   int          mIdx = 0;
   bit          mActive = 1'b0;
   bit          mFrame = 1'b0;
   bit          mUnder = 1'b0;

   logic [63:0] streamBits = '0;
   int          streamLen = 0;

   ls165_serializer #(
      .WIDTH     (8),
      .LSB_FIRST (1'b0)
   ) dut (
      .i_CLK      (clk),
      .i_CLR      (clrN),
      .i_DIN      (din),
      .i_DVALID   (dvalid),
      .o_DREADY   (dready),
      .i_SH_EN    (shEn),
      .o_QH       (qh),
      .o_QHINV    (qhInv),
      .o_FRAME    (frame),
      .o_BUSY     (busy),
      .o_UNDERRUN (underrun)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge and compare
   // every output shortly after the edge.
   task automatic applyStimulus(input bit clr, input bit dv, input logic [7:0] d,
                                input bit sh, output bit accepted);
      bit newBit;
      bit expQh;
      bit expInv;
      bit expReady;
      clrN   = clr;
      dvalid = dv;
      din    = d;
      shEn   = sh;
      #1;
      expReady = clr && (mPend.size() == 0);
      checkOutput("dready", dready, expReady);
      accepted = clr && dv && (mPend.size() == 0);
      @(posedge clk);
      newBit = 1'b0;
      if (!clr) begin
         mPend.delete();
         mActive = 1'b0;
         mFrame  = 1'b0;
         mUnder  = 1'b0;
         mIdx    = 0;
      end else begin
         mUnder = 1'b0;
         if (!mActive) begin
            if (mPend.size() > 0) begin
               mCur    = mPend.pop_front();
               mIdx    = 0;
               mActive = 1'b1;
               mFrame  = 1'b1;
               newBit  = 1'b1;
            end
         end else if (sh) begin
            if (mIdx < 7) begin
               mIdx++;
               mFrame = 1'b0;
               newBit = 1'b1;
            end else if (mPend.size() > 0) begin
               mCur   = mPend.pop_front();
               mIdx   = 0;
               mFrame = 1'b1;
               newBit = 1'b1;
            end else begin
               mActive = 1'b0;
               mFrame  = 1'b0;
               mUnder  = 1'b1;
            end
         end
         if (accepted) begin
            mPend.push_back(d);
         end
      end
      #1;
      expQh  = mActive ? mCur[7 - mIdx] : 1'b0;
      expInv = ~expQh;
      checkOutput("qh", qh, expQh);
      checkOutput("qhinv", qhInv, expInv);
      checkOutput("frame", frame, mFrame);
      checkOutput("busy", busy, mActive);
      checkOutput("underrun", underrun, mUnder);
      if (newBit) begin
         streamBits = {streamBits[62:0], qh};
         streamLen++;
      end
   endtask

   // Offer a list of words back-to-back and run until the model drains.
   // mode 0: shift enable always on; mode 1: shift enable toggles so each bit
   // is held for two cycles.
   task automatic sendWords(input logic [7:0] words[$], input int mode);
      int idx = 0;
      int cyc = 0;
      bit acc;
      bit sh;
      while ((idx < words.size() || mActive || mPend.size() > 0) && cyc < 400) begin
         sh = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
         applyStimulus(1'b1, idx < words.size(), (idx < words.size()) ? words[idx] : 8'h00, sh, acc);
         if (acc) begin
            idx++;
         end
         cyc++;
      end
      if (cyc >= 400) begin
         checkOutput("drainTimeout", 0, 1);
      end
   endtask

   task automatic clearStream();
      streamBits = '0;
      streamLen  = 0;
   endtask

   initial begin
      logic [7:0] words[$];
      bit acc;
      int guard;

      // Reset held for two edges while a word is offered: nothing is taken.
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, acc);
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, acc);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);

      // Single word, then underrun.
      clearStream();
      words = '{8'hA5};
      sendWords(words, 0);
      checkOutput("streamA5", streamBits[7:0], 8'hA5);
      checkOutput("lenA5", streamLen, 8);

      // Two words, gapless.
      clearStream();
      words = '{8'hF0, 8'h0F};
      sendWords(words, 0);
      checkOutput("streamF00F", streamBits[15:0], 16'hF00F);
      checkOutput("lenF00F", streamLen, 16);

      // Shift enable toggling every cycle.
      clearStream();
      words = '{8'hC3};
      sendWords(words, 1);
      checkOutput("streamC3", streamBits[7:0], 8'hC3);

      // Three words offered back-to-back.
      clearStream();
      words = '{8'h3C, 8'h96, 8'hE1};
      sendWords(words, 0);
      checkOutput("stream3w", streamBits[23:0], 24'h3C96E1);
      checkOutput("len3w", streamLen, 24);

      // Reset in the middle of a word, then a fresh word.
      clearStream();
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 20) begin
         applyStimulus(1'b1, 1'b1, 8'h81, 1'b1, acc);
         guard++;
      end
      while (streamLen < 3 && guard < 40) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);
         guard++;
      end
      if (guard >= 40) begin
         checkOutput("midWordTimeout", 0, 1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, acc);
      checkOutput("midResetDready", dready, 0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, acc);
      clearStream();
      words = '{8'h55};
      sendWords(words, 0);
      checkOutput("stream55", streamBits[7:0], 8'h55);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1,
                       8'($urandom), $urandom_range(0, 3) != 0, acc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   // Watchdog so a stuck run still ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
